// File: rtl/mem_fu.sv
// mem_fu: load/store unit with a commit-gated in-order store queue and a fixed-latency word DMEM.
// Build option STORE_FWD_EN: loads forward from the youngest matching queued store instead of waiting for the queue to drain.
module mem_fu #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter int PREG_W     = 6,
  parameter int DMEM_DEPTH = 256,
  parameter int LAT        = 2,
  parameter int SQ_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [DATA_W-1:0] in_base,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [PREG_W-1:0] in_dst_preg,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              cdb_valid,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [PREG_W-1:0] cdb_preg,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_wr_en,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic              sq_full
);
  localparam int IW     = $clog2(DMEM_DEPTH);
  localparam int QW     = $clog2(SQ_DEPTH);
  localparam int CW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int LAT_M1 = LAT - 1;
  localparam logic [CW-1:0] ACC_INIT = LAT_M1[CW-1:0];
  localparam logic [QW:0]   SQ_N     = SQ_DEPTH[QW:0];

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     acc_cnt;
  logic              op_store;
  logic [IW-1:0]     op_idx;
  logic [PREG_W-1:0] op_preg;
  logic [TAG_W-1:0]  op_tag;

  logic [IW-1:0]     sq_idx  [SQ_DEPTH];
  logic [DATA_W-1:0] sq_data [SQ_DEPTH];
  logic [TAG_W-1:0]  sq_tag  [SQ_DEPTH];
  logic [QW-1:0]     head, tail;
  logic [QW:0]       cnt;

  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [DATA_W-1:0] addr, load_data;
  logic accept, push, pop, load_block, last_acc;
  logic unused_addr;

  assign addr        = in_base + in_imm;
  assign unused_addr = ^{addr[DATA_W-1:IW+2], addr[1:0]};
  assign sq_full     = (cnt == SQ_N);
  assign in_ready    = (state == IDLE) && !flush && !(in_is_store && sq_full) && !load_block;
  assign accept      = in_valid && in_ready;
  assign push        = accept && in_is_store;
  // Only the queue head can retire; other commit tags belong to non-store ops.
  assign pop         = commit_valid && (cnt != '0) && (commit_tag == sq_tag[head]);
  assign last_acc    = (state == ACCESS) && (acc_cnt == '0);
  assign cdb_valid   = (state == RESP);

`ifdef STORE_FWD_EN
  assign load_block = 1'b0;
  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    load_data = dmem[op_idx];
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (((QW+1)'(i) < cnt) && (sq_idx[head + QW'(i)] == op_idx))
        load_data = sq_data[head + QW'(i)];
    end
  end
`else
  assign load_block = !in_is_store && (cnt != '0);
  assign load_data  = dmem[op_idx];
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  if (acc_cnt == '0) state_nx = RESP;
      RESP:    if (cdb_grant) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt   <= '0;
      op_store  <= 1'b0;
      op_idx    <= '0;
      op_preg   <= '0;
      op_tag    <= '0;
      cdb_tag   <= '0;
      cdb_preg  <= '0;
      cdb_data  <= '0;
      cdb_wr_en <= 1'b0;
    end else begin
      if (accept) begin
        op_store <= in_is_store;
        op_idx   <= addr[IW+1:2];
        op_preg  <= in_dst_preg;
        op_tag   <= in_tag;
        acc_cnt  <= ACC_INIT;
      end else if ((state == ACCESS) && (acc_cnt != '0)) begin
        acc_cnt <= acc_cnt - 1'b1;
      end
      if (flush) begin
        cdb_tag   <= '0;
        cdb_preg  <= '0;
        cdb_data  <= '0;
        cdb_wr_en <= 1'b0;
      end else if (last_acc) begin
        cdb_tag   <= op_tag;
        cdb_preg  <= op_store ? '0 : op_preg;
        cdb_data  <= op_store ? '0 : load_data;
        cdb_wr_en <= !op_store;
      end
    end
  end

  // A flush drops every queued store; a same-cycle commit still reaches DMEM below.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sq_idx[tail]  <= addr[IW+1:2];
      sq_data[tail] <= in_data;
      sq_tag[tail]  <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && pop) dmem[sq_idx[head]] <= sq_data[head];
  end
endmodule

// File: tb/tb_mem_fu.sv
// Randomized bench for mem_fu against a transaction-level model: a store-queue list plus a word memory map.
module tb_mem_fu;
  localparam int LAT = 2;
  localparam int SQD = 4;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_is_store;
  logic [31:0] in_base, in_data, in_imm;
  logic [5:0]  in_dst_preg;
  logic [4:0]  in_tag;
  logic        cdb_valid, cdb_grant, cdb_wr_en;
  logic [4:0]  cdb_tag;
  logic [5:0]  cdb_preg;
  logic [31:0] cdb_data;
  logic        commit_valid, flush, sq_full;
  logic [4:0]  commit_tag;

  always #5 clk = ~clk;

  mem_fu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_base(in_base), .in_data(in_data), .in_imm(in_imm), .in_dst_preg(in_dst_preg), .in_tag(in_tag),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_preg(cdb_preg),
    .cdb_data(cdb_data), .cdb_wr_en(cdb_wr_en), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .flush(flush), .sq_full(sq_full)
  );

  typedef struct { logic [7:0] idx; logic [31:0] data; logic [4:0] tag; } sq_e_t;
  sq_e_t       sq_q[$];
  logic [31:0] mem_m [256];
  bit          known [256];
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_commit(input logic [4:0] t);
    if (sq_q.size() != 0 && sq_q[0].tag == t) begin
      mem_m[sq_q[0].idx] = sq_q[0].data;
      known[sq_q[0].idx] = 1'b1;
      void'(sq_q.pop_front());
    end
  endtask

  task automatic do_commit(input logic [4:0] t);
    commit_valid = 1'b1; commit_tag = t;
    @(posedge clk); #1;
    commit_valid = 1'b0;
    model_commit(t);
    @(negedge clk);
    chk("sq_full_commit", sq_full, sq_q.size() == SQD);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input bit st, input logic [31:0] base, input logic [31:0] imm, input logic [31:0] data,
                       input logic [5:0] preg, input logic [4:0] tag, input int gd,
                       input bit cm, input logic [4:0] cm_tag);
    logic [31:0] a, exp_d;
    logic [7:0]  idx;
    bit          exp_rdy, dknown;
    sq_e_t       e;
    a = base + imm;
    idx = a[9:2];
    in_valid = 1'b1; in_is_store = st; in_base = base; in_imm = imm; in_data = data;
    in_dst_preg = preg; in_tag = tag; commit_valid = cm; commit_tag = cm_tag;
    exp_rdy = !(st && sq_q.size() == SQD) && !(!FWD && !st && sq_q.size() != 0);
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy);
    if (!exp_rdy) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      if (cm) model_commit(cm_tag);
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; commit_valid = 1'b0;
    if (cm) model_commit(cm_tag);
    dknown = 1'b1; exp_d = '0;
    if (!st) begin
      dknown = known[idx]; exp_d = mem_m[idx];
      foreach (sq_q[i]) if (sq_q[i].idx == idx) begin exp_d = sq_q[i].data; dknown = 1'b1; end
    end else begin
      e.idx = idx; e.data = data; e.tag = tag;
      sq_q.push_back(e);
    end
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("busy_valid", cdb_valid, 0);
      chk("busy_ready", in_ready, 0);
      if (k == 0) chk("sq_full", sq_full, sq_q.size() == SQD);
      @(posedge clk); #1;
    end
    cdb_grant = (gd == 0);
    for (int g = 0; g <= gd; g++) begin
      @(negedge clk);
      chk("cdb_valid", cdb_valid, 1);
      chk("cdb_tag", cdb_tag, tag);
      chk("cdb_preg", cdb_preg, st ? 6'd0 : preg);
      chk("cdb_wr_en", cdb_wr_en, !st);
      if (dknown) chk("cdb_data", cdb_data, exp_d);
      chk("resp_ready", in_ready, 0);
      @(posedge clk); #1;
      if (g == gd - 1) cdb_grant = 1'b1;
    end
    cdb_grant = 1'b0;
    @(negedge clk);
    chk("after_grant_valid", cdb_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, d;
    logic [4:0]  t;
    int          r;
    reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_base = '0; in_data = '0; in_imm = '0;
    in_dst_preg = '0; in_tag = '0; cdb_grant = 1'b0; commit_valid = 1'b0; commit_tag = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_preg", cdb_preg, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_cdb_wr_en", cdb_wr_en, 0);
    chk("rst_sq_full", sq_full, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // store, commit, load back through DMEM
    do_op(1, 32'h100, 32'h4, 32'hDEADBEEF, 6'd0, 5'd3, 0, 0, 5'd0);
    do_commit(5'd3);
    do_op(0, 32'h104, 32'h0, 32'h0, 6'd9, 5'd4, 0, 0, 5'd0);

    // load behind an uncommitted store to the same word
    do_op(1, 32'h200, 32'h0, 32'h12345678, 6'd0, 5'd5, 0, 0, 5'd0);
    do_op(0, 32'h200, 32'h0, 32'h0, 6'd10, 5'd6, 0, 0, 5'd0);
    do_commit(5'd5);
    do_op(0, 32'h1F0, 32'h10, 32'h0, 6'd11, 5'd7, 0, 0, 5'd0);

    // fill queue, full blocking, registered full, push+pop
    for (int i = 0; i < 4; i++)
      do_op(1, 32'h40 + 32'(4 * i), 32'h0, $urandom, 6'd0, 5'(8 + i), 1, 0, 5'd0);
    do_op(1, 32'h50, 32'h0, 32'h5555AAAA, 6'd0, 5'd12, 0, 0, 5'd0);
    do_commit(5'd8);
    do_op(1, 32'h50, 32'h0, 32'h5555AAAA, 6'd0, 5'd12, 0, 1, 5'd9);
    do_op(1, 32'h54, 32'h0, 32'h6666BBBB, 6'd0, 5'd13, 0, 0, 5'd0);
    do_op(1, 32'h58, 32'h0, 32'h77777777, 6'd0, 5'd14, 0, 1, 5'd10);
    for (int i = 11; i < 14; i++) do_commit(5'(i));

    // long grant stall
    do_op(0, 32'h40, 32'h8, 32'h0, 6'd33, 5'd15, 5, 0, 5'd0);

    // flush during ACCESS with two queued stores and a head commit
    do_op(1, 32'h84, 32'h0, 32'hCAFEF00D, 6'd0, 5'd16, 0, 0, 5'd0);
    do_commit(5'd16);
    do_op(1, 32'h80, 32'h0, 32'h0BADF00D, 6'd0, 5'd17, 0, 0, 5'd0);
    in_valid = 1'b1; in_is_store = 1'b1; in_base = 32'h84; in_imm = '0; in_data = 32'hBAD0BAD0; in_tag = 5'd18;
    @(negedge clk);
    chk("fl_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1; commit_valid = 1'b1; commit_tag = 5'd17;
    @(negedge clk);
    chk("fl_busy_valid", cdb_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0; commit_valid = 1'b0;
    model_commit(5'd17);
    sq_q.delete();
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("fl_valid", cdb_valid, 0);
      if (k == 0) begin chk("fl_ready", in_ready, 1); chk("fl_sq_full", sq_full, 0); end
      @(posedge clk); #1;
    end
    do_op(0, 32'h80, 32'h0, 32'h0, 6'd20, 5'd19, 0, 0, 5'd0);
    do_op(0, 32'h84, 32'h0, 32'h0, 6'd21, 5'd20, 1, 0, 5'd0);

    // reset mid-ACCESS drops queued stores but keeps DMEM
    do_op(1, 32'h40, 32'h0, 32'h99999999, 6'd0, 5'd21, 0, 0, 5'd0);
    in_valid = 1'b1; in_is_store = 1'b1; in_base = 32'h44; in_imm = '0; in_data = 32'h88888888; in_tag = 5'd22;
    @(negedge clk);
    chk("rs_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_store = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sq_q.delete();
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("rs_valid", cdb_valid, 0);
      if (k == 0) begin chk("rs_ready", in_ready, 1); chk("rs_sq_full", sq_full, 0); end
      @(posedge clk); #1;
    end
    do_op(0, 32'h40, 32'h0, 32'h0, 6'd22, 5'd23, 0, 0, 5'd0);

    // preload a small window, then random traffic with aliasing upper address bits
    for (int i = 0; i < 16; i++) begin
      a = $urandom; a[9:2] = 8'(i); b = $urandom;
      do_op(1, b, a - b, $urandom, 6'd0, 5'(i), 0, 0, 5'd0);
      do_commit(5'(i));
    end
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (sq_q.size() != 0 && $urandom_range(0, 3) != 0) t = sq_q[0].tag;
      else t = 5'($urandom);
      if (r < 3) begin
        do_commit(t);
      end else begin
        a = $urandom; a[9:2] = 8'($urandom_range(0, 15)); b = $urandom; d = $urandom;
        do_op(r < 6, b, a - b, d, 6'($urandom), 5'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 4) == 0, t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
